// File: rtl/display_mux.sv
// display_mux: two-digit seven-segment multiplexer with blanking gap,
// leading-zero suppression and overflow dash, fed by counter results.
module display_mux #(
   parameter int unsigned REFRESH_CYCLES     = 1000,
   parameter int unsigned GAP_CYCLES         = 16,
   parameter bit          BLANK_LEADING_ZERO = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] ten_count,
   input  logic [3:0] unit_count,
   output logic [6:0] segments,
   output logic       digit,
   output logic       overflow
);

   localparam int unsigned PW = $clog2(REFRESH_CYCLES);
   localparam logic [PW-1:0] PH_LAST = PW'(REFRESH_CYCLES - 1);
   localparam logic [6:0] SEG_OFF  = 7'h00;
   localparam logic [6:0] SEG_DASH = 7'h40;

   typedef enum logic {
      UNITS = 1'b0,
      TENS  = 1'b1
   } phase_e;

   phase_e        state_q;
   phase_e        state_d;
   logic [PW-1:0] ph_q;
   logic [PW-1:0] ph_d;
   logic [3:0]    tens_q;
   logic [3:0]    units_q;
   logic [3:0]    sel_val;
   logic          in_gap;
   logic          lead_blank;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

   // Latch the counter result on the load strobe; last load wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tens_q  <= 4'd0;
         units_q <= 4'd0;
      end else if (load) begin
         tens_q  <= ten_count;
         units_q <= unit_count;
      end
   end

   // Phase counter and digit-select state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= UNITS;
         ph_q    <= '0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
      end
   end

   // Advance the phase; swap digits when the phase wraps.
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q + 1'b1;
      if (ph_q == PH_LAST) begin
         ph_d = '0;
         unique case (state_q)
            UNITS:   state_d = TENS;
            TENS:    state_d = UNITS;
            default: state_d = UNITS;
         endcase
      end
   end

   assign digit    = (state_q == TENS);
   assign overflow = (tens_q > 4'd9) | (units_q > 4'd9);
   assign in_gap   = (32'(ph_q) < GAP_CYCLES);
   assign lead_blank = BLANK_LEADING_ZERO
                     && (state_q == TENS)
                     && (tens_q == 4'd0);

   // Segment select: gap, then overflow dash, then leading blank, then digit.
   always_comb begin
      segments = SEG_OFF;
      sel_val  = (state_q == TENS) ? tens_q : units_q;
      if (in_gap)
         segments = SEG_OFF;
      else if (overflow)
         segments = SEG_DASH;
      else if (lead_blank)
         segments = SEG_OFF;
      else
         segments = seg_decode(sel_val);
   end

endmodule

// File: tb/tb_display_mux.sv
// tb_display_mux: directed table-driven checks of display_mux
// with REFRESH_CYCLES=8, GAP_CYCLES=2, both leading-zero settings.
module tb_display_mux;

   localparam int R = 8;
   localparam int G = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       load = 1'b0;
   logic [3:0] ten_count = 4'd0;
   logic [3:0] unit_count = 4'd0;
   logic [6:0] segments;
   logic       digit;
   logic       overflow;
   logic [6:0] segments_nz;
   logic       digit_nz;
   logic       overflow_nz;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [3:0] ten;
      logic [3:0] unit;
      logic [6:0] eu;
      logic [6:0] et;
      logic [6:0] etn;
      logic       eo;
   } vec_t;

   vec_t vecs [6];

   display_mux #(
      .REFRESH_CYCLES(R),
      .GAP_CYCLES(G),
      .BLANK_LEADING_ZERO(1'b1)
   ) u_dut (
      .clk(clk),
      .reset(reset),
      .load(load),
      .ten_count(ten_count),
      .unit_count(unit_count),
      .segments(segments),
      .digit(digit),
      .overflow(overflow)
   );

   display_mux #(
      .REFRESH_CYCLES(R),
      .GAP_CYCLES(G),
      .BLANK_LEADING_ZERO(1'b0)
   ) u_nz (
      .clk(clk),
      .reset(reset),
      .load(load),
      .ten_count(ten_count),
      .unit_count(unit_count),
      .segments(segments_nz),
      .digit(digit_nz),
      .overflow(overflow_nz)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int k,
                      input logic [6:0] act, input logic [6:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s k=%0d: got %h expected %h", name, k, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Expected outputs at sample k after reset release (k=0: ph=0, units).
   task automatic check_sample(input int k, input logic [6:0] eu,
                               input logic [6:0] et, input logic [6:0] etn,
                               input logic eo);
      int p;
      logic d;
      logic [6:0] es;
      logic [6:0] esn;
      p = k % R;
      d = ((k / R) % 2) == 1;
      es  = (p < G) ? 7'h00 : (d ? et : eu);
      esn = (p < G) ? 7'h00 : (d ? etn : eu);
      chk("digit", k, {6'd0, digit}, {6'd0, d});
      chk("digit_nz", k, {6'd0, digit_nz}, {6'd0, d});
      chk("segments", k, segments, es);
      chk("segments_nz", k, segments_nz, esn);
      chk("overflow", k, {6'd0, overflow}, {6'd0, eo});
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      load  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_digit", 0, {6'd0, digit}, 7'd0);
      chk("rst_ovf", 0, {6'd0, overflow}, 7'd0);
      chk("rst_seg", 0, segments, 7'h00);
      reset = 1'b0;
   endtask

   initial begin
      vecs[0] = '{ten: 4'd4,  unit: 4'd7,  eu: 7'h07, et: 7'h66,
                  etn: 7'h66, eo: 1'b0};
      vecs[1] = '{ten: 4'd0,  unit: 4'd5,  eu: 7'h6D, et: 7'h00,
                  etn: 7'h3F, eo: 1'b0};
      vecs[2] = '{ten: 4'd12, unit: 4'd3,  eu: 7'h40, et: 7'h40,
                  etn: 7'h40, eo: 1'b1};
      vecs[3] = '{ten: 4'd9,  unit: 4'd9,  eu: 7'h6F, et: 7'h6F,
                  etn: 7'h6F, eo: 1'b0};
      vecs[4] = '{ten: 4'd0,  unit: 4'd0,  eu: 7'h3F, et: 7'h00,
                  etn: 7'h3F, eo: 1'b0};
      vecs[5] = '{ten: 4'd15, unit: 4'd15, eu: 7'h40, et: 7'h40,
                  etn: 7'h40, eo: 1'b1};

      // Reset cadence with value 00.
      do_reset();
      for (int k = 0; k < 2 * R; k++) begin
         check_sample(k, 7'h3F, 7'h00, 7'h3F, 1'b0);
         step();
      end

      // Table vectors: load right after reset, check a full period.
      for (int v = 0; v < 6; v++) begin
         do_reset();
         check_sample(0, 7'h3F, 7'h00, 7'h3F, 1'b0);
         ten_count  = vecs[v].ten;
         unit_count = vecs[v].unit;
         load = 1'b1;
         for (int k = 1; k <= 2 * R; k++) begin
            step();
            load = 1'b0;
            check_sample(k, vecs[v].eu, vecs[v].et, vecs[v].etn,
                         vecs[v].eo);
         end
      end

      // Overflow then 9/9 without reset, mid-phase.
      do_reset();
      ten_count = 4'd12; unit_count = 4'd3; load = 1'b1;
      step();
      load = 1'b0;
      for (int k = 1; k < 4; k++) begin
         check_sample(k, 7'h40, 7'h40, 7'h40, 1'b1);
         step();
      end
      ten_count = 4'd9; unit_count = 4'd9; load = 1'b1;
      check_sample(4, 7'h40, 7'h40, 7'h40, 1'b1);
      for (int k = 5; k <= 2 * R; k++) begin
         step();
         load = 1'b0;
         check_sample(k, 7'h6F, 7'h6F, 7'h6F, 1'b0);
      end

      // Back-to-back loads 1/1, 2/2, 3/3; cadence unaffected.
      do_reset();
      ten_count = 4'd1; unit_count = 4'd1; load = 1'b1;
      step();
      check_sample(1, 7'h06, 7'h06, 7'h06, 1'b0);
      ten_count = 4'd2; unit_count = 4'd2;
      step();
      check_sample(2, 7'h5B, 7'h5B, 7'h5B, 1'b0);
      ten_count = 4'd3; unit_count = 4'd3;
      for (int k = 3; k <= 2 * R; k++) begin
         step();
         load = 1'b0;
         check_sample(k, 7'h4F, 7'h4F, 7'h4F, 1'b0);
      end

      // Asynchronous reset mid tens phase (ph=5), then cadence restart.
      do_reset();
      ten_count = 4'd12; unit_count = 4'd3; load = 1'b1;
      for (int k = 1; k <= R + 5; k++) begin
         step();
         load = 1'b0;
         check_sample(k, 7'h40, 7'h40, 7'h40, 1'b1);
      end
      #2;
      reset = 1'b1;
      #1;
      chk("async_digit", R + 5, {6'd0, digit}, 7'd0);
      chk("async_ovf", R + 5, {6'd0, overflow}, 7'd0);
      chk("async_seg", R + 5, segments, 7'h00);
      chk("async_seg_nz", R + 5, segments_nz, 7'h00);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k <= 2 * R; k++) begin
         check_sample(k, 7'h3F, 7'h00, 7'h3F, 1'b0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
